// File: rtl/bcd_disp_pkg.sv
// Shared display definitions: scan states and 7-segment glyphs.
// Glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment glyph.
// Non-decimal codes render as a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Glyph lookup; 10-15 fall through to the dash
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking,
// frame-synchronous display update and leading-zero blanking.
module bcd_7seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        bcd_valid,
    input  logic        lzb_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] LAST_SLOT  = CW'(DIGIT_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    digit, digit_nx;
    logic          wrap;

    logic [15:0]   pend_bcd, disp_bcd;
    logic [3:0]    pend_dp, disp_dp;
    logic          pend_flag;
    logic          copy;

    logic [3:0]    cur_val;
    logic [6:0]    glyph;
    logic [3:0]    lz_off;
    logic          lz_run;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    // Display only changes at the start of digit 0 to avoid tearing
    assign copy = (state == BLANK) && (cnt == '0) && (digit == 2'd0);

    // Pending capture and frame-aligned transfer to the display copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            disp_bcd  <= '0;
            disp_dp   <= '0;
        end else begin
            if (copy && pend_flag) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
            end
            if (bcd_valid) begin
                pend_bcd  <= bcd_in;
                pend_dp   <= dp_in;
                pend_flag <= 1'b1;
            end else if (copy) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            digit <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            digit <= digit_nx;
        end
    end

    // Slot sequencing: BLANK then SHOW, advance digit at slot end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        digit_nx = digit;
        wrap     = 1'b0;
        unique case (state)
            BLANK: begin
                if (cnt == LAST_BLANK) state_nx = SHOW;
            end
            SHOW: begin
                if (cnt == LAST_SLOT) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    digit_nx = digit + 2'd1;
                    wrap     = (digit == 2'd3);
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    assign cur_val = disp_bcd[{digit, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd   (cur_val),
        .seg_n (glyph)
    );

    // Leading-zero mask, walking down from the top digit
    always_comb begin
        lz_off = 4'b0000;
        lz_run = lzb_en;
        for (int i = 3; i >= 1; i--) begin
            lz_run    = lz_run && (disp_bcd[i*4 +: 4] == 4'd0) && !disp_dp[i];
            lz_off[i] = lz_run;
        end
    end

    // Next pin values from the current slot
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state == SHOW && !lz_off[digit]) begin
            an_d  = ~(4'b0001 << digit);
            seg_d = glyph;
            dp_d  = ~disp_dp[digit];
        end
    end

    // Output registers keep anodes and segments aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= AN_OFF;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an_n       <= an_d;
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Directed bench for bcd_7seg_scanner with 8-cycle slots, 2 blank.
// Frames are checked cycle by cycle against hand-computed glyphs.
module tb_bcd_7seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        bcd_valid;
    logic        lzb_en;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        logic [27:0] seg;
        logic [3:0]  on;
    } vec_t;

    vec_t vecs[7];

    bcd_7seg_scanner #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .bcd_valid  (bcd_valid),
        .lzb_en     (lzb_en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Check 32 cycles following a frame_done sample
    task automatic check_frame(input string name, input logic [27:0] es,
                               input logic [3:0] on, input logic [3:0] dpl);
        int slot, pos;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fd;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            bcd_valid = 1'b0;
            slot = k / 8;
            pos  = k % 8;
            e_fd = (k == 31);
            if (pos < 2 || !on[slot]) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << slot);
                e_seg = es[slot*7 +: 7];
                e_dp  = ~dpl[slot];
            end
            tests++;
            if (an_n !== e_an || seg_n !== e_seg || dp_n !== e_dp
                || frame_done !== e_fd) begin
                fails++;
                $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                         name, k, an_n, seg_n, dp_n, frame_done,
                         e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL %s frame_done timeout: got %b, want 1", name, frame_done);
        end
    endtask

    task automatic strobe(input logic [15:0] b, input logic [3:0] d);
        bcd_in    = b;
        dp_in     = d;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0011};
        vecs[1] = '{16'h00AF, 4'b0010, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h3F}, 4'b1111};
        vecs[2] = '{16'h00AF, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h3F, 7'h3F}, 4'b0011};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};
        vecs[4] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h40, 7'h40, 7'h40}, 4'b0111};
        vecs[5] = '{16'h9865, 4'b1001, 1'b0, {7'h10, 7'h00, 7'h02, 7'h12}, 4'b1111};
        vecs[6] = '{16'h1000, 4'b0000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}, 4'b1111};

        rst_n     = 1'b0;
        bcd_in    = '0;
        dp_in     = '0;
        bcd_valid = 1'b0;
        lzb_en    = 1'b0;

        repeat (3) @(negedge clk);
        tests++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset: got an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0",
                     an_n, seg_n, dp_n, frame_done);
        end

        // Release with 1234 strobed on the first edge: frame 1 still 0000
        rst_n     = 1'b1;
        bcd_in    = 16'h1234;
        dp_in     = 4'b0000;
        bcd_valid = 1'b1;
        check_frame("first_frame", {4{7'h40}}, 4'hF, 4'h0);
        check_frame("frame_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0);

        for (int v = 0; v < 7; v++) begin
            repeat (3) @(negedge clk);
            lzb_en = vecs[v].lzb;
            strobe(vecs[v].bcd, vecs[v].dp);
            wait_fd($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), vecs[v].seg, vecs[v].on, vecs[v].dp);
        end

        // Two strobes in one frame: only the later one is shown
        lzb_en = 1'b0;
        repeat (3) @(negedge clk);
        strobe(16'h1111, 4'h0);
        repeat (6) @(negedge clk);
        strobe(16'h2222, 4'h0);
        wait_fd("overwrite");
        check_frame("overwrite", {4{7'h24}}, 4'hF, 4'h0);

        // Strobe on the copy cycle lands one frame later
        bcd_in    = 16'h5555;
        dp_in     = 4'h0;
        bcd_valid = 1'b1;
        check_frame("copy_cycle_old", {4{7'h24}}, 4'hF, 4'h0);
        check_frame("copy_cycle_new", {4{7'h12}}, 4'hF, 4'h0);

        // Asynchronous reset during digit 2's SHOW
        repeat (21) @(negedge clk);
        tests++;
        if (an_n !== 4'b1011 || seg_n !== 7'h12) begin
            fails++;
            $display("FAIL pre_reset: got an=%b seg=%h, want 1011 12", an_n, seg_n);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0",
                     an_n, seg_n, dp_n, frame_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_frame("after_reset", {4{7'h40}}, 4'hF, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
